// File: rtl/ram_pkg.sv
// Shared constants, response record and stall-LFSR step for the two-port simulation RAM.
package ram_pkg;

  localparam logic [31:0] NOP_INST_DEF      = 32'h0000_0013;
  localparam logic [31:0] CHAR_OUT_ADDR_DEF = 32'h0002_0000;
  localparam logic [31:0] SIM_CTRL_ADDR_DEF = 32'h0002_0002;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int RSP_DATA_W = 32;

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [RSP_DATA_W-1:0] data;
  } rsp_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/ram_rsp_pipe.sv
// Fixed-latency response delay line; every stage clears on reset so in-flight responses are dropped.
module ram_rsp_pipe
  import ram_pkg::*;
#(
  parameter int  RD_LAT = 1,
  parameter type pipe_t = rsp_t,
  parameter pipe_t IDLE = '0
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  pipe_t rsp_i,
  output pipe_t rsp_o
);

  pipe_t stg_p [RD_LAT];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < RD_LAT; s++) stg_p[s] <= IDLE;
    end else begin
      stg_p[0] <= rsp_i;
      for (int s = 1; s < RD_LAT; s++) stg_p[s] <= stg_p[s-1];
    end
  end

  assign rsp_o = stg_p[RD_LAT-1];

endmodule

// File: rtl/ram_2p_pipe.sv
// Two-port simulation RAM: LSU data port with MMIO decode and optional random back-pressure,
// plus a read-only fetch port, both answering after a fixed RD_LAT.
module ram_2p_pipe
  import ram_pkg::*;
#(
  parameter int                 DATA_W        = 32,
  parameter int                 ADDR_W        = 32,
  parameter int                 DEPTH         = 65536,
  parameter int                 RD_LAT        = 1,
  parameter bit                 WRITE_FIRST   = 1'b1,
  parameter logic [15:0]        STALL_SEED    = 16'hACE1,
  parameter logic [ADDR_W-1:0]  CHAR_OUT_ADDR = ADDR_W'(CHAR_OUT_ADDR_DEF),
  parameter logic [ADDR_W-1:0]  SIM_CTRL_ADDR = ADDR_W'(SIM_CTRL_ADDR_DEF),
  parameter logic [DATA_W-1:0]  NOP_INST      = DATA_W'(NOP_INST_DEF)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_en_i,
  input  logic                d_req_i,
  output logic                d_gnt_o,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_err_o,
  input  logic                i_req_i,
  output logic                i_gnt_o,
  input  logic [ADDR_W-1:0]   i_addr_i,
  output logic                i_rvalid_o,
  output logic [DATA_W-1:0]   i_rdata_o,
  output logic                i_err_o,
  output logic                char_valid_o,
  output logic [7:0]          char_o,
  output logic                sim_halt_o,
  output logic [7:0]          sim_code_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int NB    = DATA_W / 8;
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(DEPTH) << 2;

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [DATA_W-1:0] data;
  } rsp_w_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [15:0]       lfsr_q;
  logic [IDX_W-1:0]  d_idx, i_idx;
  logic              d_char_hit, d_halt_hit, d_mmio, d_err, d_mem_wr;
  logic              d_char_wr, d_halt_wr, i_err, i_collide;
  logic [DATA_W-1:0] d_old, i_old, d_merged;
  rsp_w_t            d_rsp_in, d_rsp_out, i_rsp_in, i_rsp_out;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old,
                                                     input logic [DATA_W-1:0] wd,
                                                     input logic [NB-1:0]     be);
    logic [DATA_W-1:0] res;
    res = old;
    for (int b = 0; b < NB; b++) if (be[b]) res[8*b +: 8] = wd[8*b +: 8];
    return res;
  endfunction

  // Backdoor read for hierarchical access; indices beyond the array read as zero.
  function automatic logic [DATA_W-1:0] get_word(input logic [ADDR_W-1:0] idx);
    if (idx >= ADDR_W'(DEPTH)) return '0;
    return mem[idx[IDX_W-1:0]];
  endfunction

  assign d_gnt_o = d_req_i & (~stall_en_i | lfsr_q[0]);
  assign i_gnt_o = i_req_i;

  assign d_idx      = d_addr_i[IDX_W+1:2];
  assign i_idx      = i_addr_i[IDX_W+1:2];
  assign d_char_hit = d_addr_i[ADDR_W-1:2] == CHAR_OUT_ADDR[ADDR_W-1:2];
  assign d_halt_hit = d_addr_i[ADDR_W-1:2] == SIM_CTRL_ADDR[ADDR_W-1:2];
  assign d_mmio     = d_char_hit | d_halt_hit;
  assign d_err      = ({1'b0, d_addr_i} >= MEM_BYTES) & ~d_mmio;
  assign i_err      = (i_addr_i[1:0] != 2'b00) | ({1'b0, i_addr_i} >= MEM_BYTES);
  assign d_mem_wr   = d_gnt_o & d_we_i & ~d_mmio & ~d_err;
  assign d_char_wr  = d_gnt_o & d_we_i & d_char_hit & d_be_i[0];
  assign d_halt_wr  = d_gnt_o & d_we_i & d_halt_hit & d_be_i[2];
  assign i_collide  = d_mem_wr & i_gnt_o & (d_idx == i_idx);

  assign d_old    = mem[d_idx];
  assign i_old    = mem[i_idx];
  assign d_merged = merge_bytes(d_old, d_wdata_i, d_be_i);

  always_ff @(posedge clk_i) begin
    if (d_mem_wr) begin
      for (int b = 0; b < NB; b++)
        if (d_be_i[b]) mem[d_idx][8*b +: 8] <= d_wdata_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= STALL_SEED;
    else       lfsr_q <= lfsr_step(lfsr_q);
  end

  always_comb begin
    d_rsp_in.valid = d_gnt_o;
    d_rsp_in.err   = d_gnt_o & d_err;
    d_rsp_in.data  = '0;
    if (d_gnt_o && !d_we_i && !d_mmio && !d_err) d_rsp_in.data = d_old;
  end

  // On a same-edge write/fetch collision the merged word is the post-write contents.
  always_comb begin
    i_rsp_in.valid = i_gnt_o;
    i_rsp_in.err   = i_gnt_o & i_err;
    i_rsp_in.data  = NOP_INST;
    if (i_gnt_o && !i_err) i_rsp_in.data = (WRITE_FIRST && i_collide) ? d_merged : i_old;
  end

  ram_rsp_pipe #(.RD_LAT(RD_LAT), .pipe_t(rsp_w_t), .IDLE('0)) u_d_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rsp_i (d_rsp_in),
    .rsp_o (d_rsp_out)
  );

  ram_rsp_pipe #(.RD_LAT(RD_LAT), .pipe_t(rsp_w_t), .IDLE({1'b0, 1'b0, NOP_INST})) u_i_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rsp_i (i_rsp_in),
    .rsp_o (i_rsp_out)
  );

  assign d_rvalid_o = d_rsp_out.valid;
  assign d_err_o    = d_rsp_out.err;
  assign d_rdata_o  = d_rsp_out.data;
  assign i_rvalid_o = i_rsp_out.valid;
  assign i_err_o    = i_rsp_out.err;
  assign i_rdata_o  = i_rsp_out.data;

  // The exit code is captured only by the first halt write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      char_valid_o <= 1'b0;
      char_o       <= '0;
      sim_halt_o   <= 1'b0;
      sim_code_o   <= '0;
    end else begin
      char_valid_o <= d_char_wr;
      if (d_char_wr) char_o <= d_wdata_i[7:0];
      if (d_halt_wr && !sim_halt_o) begin
        sim_halt_o <= 1'b1;
        sim_code_o <= d_wdata_i[23:16];
      end
    end
  end

endmodule

// File: tb/tb_ram_2p_pipe.sv
// Scoreboard bench for ram_2p_pipe: directed cases plus randomized traffic against a word-level model.
`timescale 1ns/1ps
module tb_ram_2p_pipe;

  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 32;
  localparam int          DEPTH  = 65536;
  localparam int          RD_LAT = 2;
  localparam bit          WF     = 1'b1;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam logic [31:0] CHAR_A = 32'h0002_0000;
  localparam logic [31:0] SIM_A  = 32'h0002_0002;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] LIMIT  = 32'(DEPTH * 4);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_en = 1'b0;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [3:0]  d_be = 4'h0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        d_gnt_o, d_rvalid_o, d_err_o, i_gnt_o, i_rvalid_o, i_err_o;
  logic        char_valid_o, sim_halt_o;
  logic [31:0] d_rdata_o, i_rdata_o;
  logic [7:0]  char_o, sim_code_o;

  always #5 clk = ~clk;

  ram_2p_pipe #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT),
    .WRITE_FIRST(WF), .STALL_SEED(SEED)
  ) dut (
    .clk_i(clk), .rst_i(rst), .stall_en_i(stall_en),
    .d_req_i(d_req), .d_gnt_o(d_gnt_o), .d_we_i(d_we), .d_be_i(d_be),
    .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .i_req_i(i_req), .i_gnt_o(i_gnt_o), .i_addr_i(i_addr),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o), .i_err_o(i_err_o),
    .char_valid_o(char_valid_o), .char_o(char_o),
    .sim_halt_o(sim_halt_o), .sim_code_o(sim_code_o)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    longint      cyc;
  } exp_t;

  exp_t        dq[$], iq[$], cq[$];
  logic [31:0] ref_mem [int unsigned];
  int          n_cmp = 0, n_bad = 0;
  int          n_dgnt = 0, n_drsp = 0, n_char = 0;
  longint      cyc = 0;
  logic [15:0] m_lfsr = SEED;
  logic [31:0] last_d = '0, last_i = '0;
  logic        last_derr = 1'b0, last_ierr = 1'b0;
  logic [7:0]  last_char = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Stall generator from the polynomial's tap list, advanced once per clock out of reset.
  function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
    int          taps[4] = '{16, 14, 13, 11};
    logic [15:0] m = '0;
    foreach (taps[k]) m[taps[k]-1] = 1'b1;
    return s[0] ? ((s >> 1) ^ m) : (s >> 1);
  endfunction

  function automatic logic [31:0] mem_rd(input int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) m_lfsr = SEED;
    else     m_lfsr = ref_lfsr(m_lfsr);
  end

  // Model: decide this cycle's transfers, predict responses, then apply the write.
  always @(negedge clk) begin : commit
    logic        eg, mmio, err, ierr;
    int unsigned dw, iw;
    logic [31:0] rd, ibefore, nv, idat;
    if (!rst) begin
      eg = d_req && (!stall_en || m_lfsr[0]);
      chk("d_gnt", 64'(d_gnt_o), 64'(eg));
      chk("i_gnt", 64'(i_gnt_o), 64'(i_req));
      dw      = d_addr >> 2;
      iw      = i_addr >> 2;
      mmio    = (dw == (CHAR_A >> 2)) || (dw == (SIM_A >> 2));
      err     = (d_addr >= LIMIT) && !mmio;
      ibefore = mem_rd(iw);
      if (eg) begin
        n_dgnt++;
        rd = (!d_we && !mmio && !err) ? mem_rd(dw) : 32'h0;
        if (d_we && !mmio && !err) begin
          nv = mem_rd(dw);
          for (int b = 0; b < 4; b++) if (d_be[b]) nv[8*b +: 8] = d_wdata[8*b +: 8];
          ref_mem[dw] = nv;
        end
        if (d_we && dw == (CHAR_A >> 2) && d_be[0]) cq.push_back('{{24'h0, d_wdata[7:0]}, 1'b0, cyc});
        dq.push_back('{rd, err, cyc});
      end
      if (i_req) begin
        ierr = (i_addr[1:0] != 2'b00) || (i_addr >= LIMIT);
        idat = ierr ? NOP : (WF ? mem_rd(iw) : ibefore);
        iq.push_back('{idat, ierr, cyc});
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (d_rvalid_o) begin
      n_drsp++;
      if (dq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL d_rvalid_unexpected: got rvalid with data %0h, want no response", d_rdata_o);
      end else begin
        e = dq.pop_front();
        chk("d_rdata", 64'(d_rdata_o), 64'(e.data));
        chk("d_err", 64'(d_err_o), 64'(e.err));
        chk("d_latency", 64'(cyc), 64'(e.cyc + RD_LAT));
        last_d = d_rdata_o; last_derr = d_err_o;
      end
    end
    if (i_rvalid_o) begin
      if (iq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL i_rvalid_unexpected: got rvalid with data %0h, want no response", i_rdata_o);
      end else begin
        e = iq.pop_front();
        chk("i_rdata", 64'(i_rdata_o), 64'(e.data));
        chk("i_err", 64'(i_err_o), 64'(e.err));
        chk("i_latency", 64'(cyc), 64'(e.cyc + RD_LAT));
        last_i = i_rdata_o; last_ierr = i_err_o;
      end
    end
    if (char_valid_o) begin
      n_char++;
      if (cq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL char_unexpected: got char pulse %0h, want none", char_o);
      end else begin
        e = cq.pop_front();
        chk("char_o", 64'(char_o), 64'(e.data));
        chk("char_latency", 64'(cyc), 64'(e.cyc + 1));
        last_char = char_o;
      end
    end
  end

  task automatic d_op(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    d_req = 1'b1; d_we = we; d_be = be; d_addr = a; d_wdata = wd;
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic i_op(input logic [31:0] a);
    i_req = 1'b1; i_addr = a;
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while ((dq.size() + iq.size() + cq.size()) != 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (k == 50) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_%s: %0d responses outstanding, want 0", nm, dq.size() + iq.size() + cq.size());
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_d_rvalid", 64'(d_rvalid_o), 64'(0));
    chk("rst_d_rdata", 64'(d_rdata_o), 64'(0));
    chk("rst_i_rvalid", 64'(i_rvalid_o), 64'(0));
    chk("rst_i_rdata", 64'(i_rdata_o), 64'(NOP));
    chk("rst_char_valid", 64'(char_valid_o), 64'(0));
    chk("rst_sim_halt", 64'(sim_halt_o), 64'(0));
    chk("rst_sim_code", 64'(sim_code_o), 64'(0));
    rst = 1'b0;

    d_op(1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF);
    d_op(1'b0, 4'hF, 32'h100, 32'h0);
    drain("full_word");
    chk("tp_full_word", 64'(last_d), 64'(32'hDEAD_BEEF));
    chk("tp_full_word_err", 64'(last_derr), 64'(0));

    d_op(1'b1, 4'hF, 32'h104, 32'h1122_3344);
    d_op(1'b1, 4'b0100, 32'h104, 32'h00AA_0000);
    d_op(1'b0, 4'hF, 32'h104, 32'h0);
    drain("partial");
    chk("tp_partial", 64'(last_d), 64'(32'h11AA_3344));

    d_op(1'b1, 4'hF, 32'h200, 32'h0123_4567);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h200; d_wdata = 32'hCAFE_F00D;
    i_req = 1'b1; i_addr = 32'h200;
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0; i_req = 1'b0;
    drain("collision");
    chk("tp_collision", 64'(last_i), 64'(WF ? 32'hCAFE_F00D : 32'h0123_4567));

    i_op(32'h202);
    drain("fetch_misaligned");
    chk("tp_fetch_misaligned", 64'(last_i), 64'(NOP));
    chk("tp_fetch_misaligned_err", 64'(last_ierr), 64'(1));
    i_op(32'h4_0000);
    drain("fetch_oob");
    chk("tp_fetch_oob", 64'(last_i), 64'(NOP));
    chk("tp_fetch_oob_err", 64'(last_ierr), 64'(1));

    d_op(1'b1, 4'hF, 32'h0, 32'h55AA_55AA);
    d_op(1'b1, 4'hF, 32'h4_0000, 32'hFFFF_FFFF);
    d_op(1'b0, 4'hF, 32'h4_0000, 32'h0);
    drain("data_oob");
    chk("tp_data_oob_rdata", 64'(last_d), 64'(0));
    chk("tp_data_oob_err", 64'(last_derr), 64'(1));
    d_op(1'b0, 4'hF, 32'h0, 32'h0);
    drain("oob_unchanged");
    chk("tp_oob_mem_unchanged", 64'(last_d), 64'(32'h55AA_55AA));

    d_op(1'b1, 4'b0001, CHAR_A, 32'h0000_0041);
    drain("char");
    chk("tp_char", 64'(last_char), 64'(8'h41));
    d_op(1'b1, 4'b0100, CHAR_A, 32'h002A_0000);
    drain("halt");
    chk("tp_halt", 64'(sim_halt_o), 64'(1));
    chk("tp_halt_code", 64'(sim_code_o), 64'(8'h2A));
    d_op(1'b1, 4'b0100, SIM_A, 32'h0055_0000);
    d_op(1'b0, 4'hF, CHAR_A, 32'h0);
    i_op(CHAR_A);
    drain("halt_sticky");
    chk("tp_halt_sticky", 64'(sim_halt_o), 64'(1));
    chk("tp_halt_code_sticky", 64'(sim_code_o), 64'(8'h2A));
    chk("tp_mmio_read", 64'(last_d), 64'(0));
    chk("tp_mmio_read_err", 64'(last_derr), 64'(0));
    chk("tp_char_pulses", 64'(n_char), 64'(1));

    for (int k = 0; k < 16; k++) d_op(1'b1, 4'hF, 32'h1000 + 32'(k * 4), $urandom);
    drain("preload");

    stall_en = 1'b1;
    begin
      int issued = 0;
      for (int c = 0; c < 2000 && issued < 200; c++) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_be    = 4'($urandom_range(0, 15));
        d_addr  = (($urandom_range(0, 7) == 0) ? 32'h4_0000 : 32'h1000)
                  + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
        d_wdata = $urandom;
        i_req   = $urandom_range(0, 1) == 1;
        i_addr  = 32'h1000 + 32'($urandom_range(0, 15) * 4)
                  + (($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
        if (d_req) issued++;
        @(posedge clk); #1;
      end
    end
    d_req = 1'b0; d_we = 1'b0; i_req = 1'b0; stall_en = 1'b0;
    drain("random");
    chk("rsp_vs_gnt", 64'(n_drsp), 64'(n_dgnt));
    chk("char_pulses_final", 64'(n_char), 64'(1));

    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000; i_req = 1'b1; i_addr = 32'h1000;
    @(posedge clk); #1;
    d_addr = 32'h1004; i_addr = 32'h1004;
    @(posedge clk); #1;
    d_req = 1'b0; i_req = 1'b0;
    rst = 1'b1;
    dq.delete(); iq.delete(); cq.delete();
    #1;
    chk("inflight_rst_d_rvalid", 64'(d_rvalid_o), 64'(0));
    chk("inflight_rst_i_rdata", 64'(i_rdata_o), 64'(NOP));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    stall_en = 1'b1; d_req = 1'b1; d_addr = 32'h1008;
    repeat (20) @(posedge clk);
    #1;
    d_req = 1'b0; stall_en = 1'b0;
    drain("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_2p_pipe.md
Name: ram_2p_pipe

Overview:
- Parametrised two-port simulation RAM.
- One read/write data port for the LSU and one read-only instruction port for fetch, both on a req/gnt/rvalid handshake.
- Read latency is configurable, and the data port can have pseudo-random grant back-pressure injected.
- Memory-mapped character-out and simulation-control registers are decoded on the data port. The block sits in the testbench top, replacing the zero-latency combinational RAM.

Parameters:
DATA_W, 32, data/instruction word width (multiple of 8)
ADDR_W, 32, byte address width
DEPTH, 65536, words of storage (power of two)
RD_LAT, 1, request-to-response latency in cycles, legal 1..4
WRITE_FIRST, 1, same-cycle write/inst-read collision: 1 returns new data, 0 returns old
STALL_SEED, 16'hACE1, LFSR reset seed (non-zero)
CHAR_OUT_ADDR, 32'h00020000, character output register
SIM_CTRL_ADDR, 32'h00020002, simulation halt register
NOP_INST, 32'h00000013, instruction returned on error/reset

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
stall_en_i  in  1  enable random back-pressure on data port
d_req_i  in  1  data request
d_gnt_o  out  1  data grant (request accepted this cycle)
d_we_i  in  1  1 = write, 0 = read
d_be_i  in  DATA_W/8  byte enables
d_addr_i  in  ADDR_W  byte address
d_wdata_i  in  DATA_W  write data
d_rvalid_o  out  1  data response valid
d_rdata_o  out  DATA_W  data response
d_err_o  out  1  response error, qualified by d_rvalid_o
i_req_i  in  1  fetch request
i_gnt_o  out  1  fetch grant
i_addr_i  in  ADDR_W  fetch byte address
i_rvalid_o  out  1  fetch response valid
i_rdata_o  out  DATA_W  fetched instruction
i_err_o  out  1  fetch error, qualified by i_rvalid_o
char_valid_o  out  1  one-cycle pulse, character written
char_o  out  8  character
sim_halt_o  out  1  sticky halt request
sim_code_o  out  8  exit code captured with halt

Behaviour:
- Reset (async, active-high), all outputs 0 except:
  - i_rdata_o = NOP_INST.
  - LFSR = STALL_SEED.
  - Response pipelines cleared; in-flight responses are discarded, never delivered.
  - Memory contents are not reset.
- Handshake:
  - A transfer occurs on a clock edge with req & gnt.
  - i_gnt_o = i_req_i.
  - d_gnt_o = d_req_i & (~stall_en_i | lfsr[0]).
  - The 16-bit Galois LFSR (taps 16,14,13,11) advances every cycle that is out of reset.
- Response timing: every granted request, read or write, produces exactly one rvalid pulse RD_LAT cycles after the grant edge, with responses in order.
  - Each port has an independent RD_LAT-deep valid/data/err shift register.
  - Back-to-back grants give back-to-back responses.
- Word index is addr[log2(DEPTH)+1:2].
- Write path:
  - Commits at the grant edge, per byte lane where d_be_i is set.
  - The write response carries rdata = 0 and err as decoded.
- Read path:
  - Data is sampled at the grant edge, so a read granted the cycle after a write to the same word returns the written data.
- Collision (same edge: data write granted, fetch granted, same word index):
  - WRITE_FIRST=1: fetch returns the merged new word.
  - WRITE_FIRST=0: fetch returns the pre-write word.
- Data-port error:
  - Condition: d_addr_i >= DEPTH*4 and not an MMIO address.
  - The write is dropped, the read returns 0, and d_err_o=1.
- Fetch-port error:
  - Condition: i_addr_i[1:0] != 0 or i_addr_i >= DEPTH*4.
  - Returns NOP_INST with i_err_o=1.
- MMIO (word-address match, lane chosen by d_be_i):
  - Write to CHAR_OUT_ADDR with d_be_i[0] set: the cycle after the grant, char_valid_o=1 for one cycle and char_o = d_wdata_i[7:0].
  - Write to SIM_CTRL_ADDR with d_be_i[2] set: sim_halt_o is set sticky and sim_code_o = d_wdata_i[23:16], both taking effect the next cycle. A later halt write does not update sim_code_o.
  - MMIO reads return 0 with err=0. MMIO writes never modify storage.
- Backdoor:
  - DPI-exported memload, set-word and get-word routines are retained.
  - Set/get return 0 for index >= DEPTH.

Decomposition:
- Package ram_pkg:
  - NOP_INST, CHAR_OUT_ADDR, SIM_CTRL_ADDR defaults.
  - Response struct {valid, err, data}.
  - LFSR tap constant.
- Sub-module ram_rsp_pipe: a parametrised RD_LAT-stage response shift register with async reset, instantiated once per port.

Test Plan:
- Write 0xDEADBEEF to 0x100 with be=4'b1111, then read 0x100 (RD_LAT=2) -> d_rvalid_o 2 cycles after each grant; the read returns 0xDEADBEEF, err=0.
- Partial write be=4'b0100 with data 0x00AA0000 over 0x11223344 -> read returns 0x11AA3344.
- Same-edge data write 0xCAFEF00D and fetch of word 0x200 -> fetch returns 0xCAFEF00D when WRITE_FIRST=1; returns the old word when WRITE_FIRST=0.
- Fetch 0x202 or 0x40000 (DEPTH=65536) -> i_rdata_o=0x00000013, i_err_o=1. Data read at 0x40000 -> rdata 0, d_err_o=1, memory unchanged.
- Write 0x41 to 0x00020000 with be=0001 -> char_valid_o=1 for one cycle, char_o=0x41. Write 0x002A0000 to 0x00020000 with be=0100 -> sim_halt_o=1 and sim_code_o=0x2A, both sticky.
- With stall_en_i=1, 200 random requests -> gnt matches the LFSR model, response count equals grant count, and order is preserved. Asserting rst_i with 2 responses in flight -> no rvalid after reset release.
